// File: rtl/accel_pkg.sv
// Shared types and constants for the compute sequencer.
package accel_pkg;

    localparam int unsigned ADDR_W = 15;   // input/weight buffer address width
    localparam int unsigned OP_W   = 4;    // output buffer address width
    localparam int unsigned RD_LAT = 1;    // buffer read latency in cycles

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/skew_shift.sv
// Valid delay line producing the per-lane skewed feed_valid for the array.
// Lane i sees the read enable delayed by RD_LAT+i cycles; clr_i empties the line.
module skew_shift
    import accel_pkg::*;
#(
    parameter int unsigned ARR_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                valid_i,
    output logic [ARR_SIZE-1:0] valid_o
);

    localparam int unsigned DEPTH = RD_LAT + ARR_SIZE - 1;

    logic [DEPTH-1:0] line_q;

    // Shift the read enable in at bit 0; reset and clear both empty the line.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            line_q <= '0;
        end else begin
            line_q <= DEPTH'({line_q, valid_i});
        end
    end

    assign valid_o = line_q[DEPTH-1:RD_LAT-1];

endmodule

// File: rtl/compute_sequencer.sv
// Job sequencer for a systolic array: clears accumulators, streams k_len
// input/weight reads, flushes the array, then writes ARR_SIZE result rows.
// Optional feature: define SEQ_ABORT_EN to honour the abort input.
module compute_sequencer
    import accel_pkg::*;
#(
    parameter int unsigned ARR_SIZE = 4,
    parameter int unsigned K_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    input  logic [ADDR_W-1:0]   inp_base,
    input  logic [ADDR_W-1:0]   wt_base,
    input  logic [OP_W-1:0]     op_addr,
    input  logic                abort,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                err,
    output logic                inp_rd_en,
    output logic [ADDR_W-1:0]   inp_rd_addr,
    output logic                wt_rd_en,
    output logic [ADDR_W-1:0]   wt_rd_addr,
    output logic [ARR_SIZE-1:0] feed_valid,
    output logic                acc_reset,
    output logic                acc_capture,
    output logic [OP_W-1:0]     acc_op_addr
);

    localparam int unsigned FL_W  = $clog2(2 * ARR_SIZE);
    localparam int unsigned CNT_W = (K_W > FL_W) ? K_W : FL_W;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [K_W-1:0]    k_len_q;
    logic [ADDR_W-1:0] inp_base_q;
    logic [ADDR_W-1:0] wt_base_q;
    logic [OP_W-1:0]   op_addr_q;
    logic              err_q;
    logic              aborted_q;

    logic accept;
    logic zero_req;
    logic last_feed;
    logic abort_hit;

    assign accept    = (state_q == S_IDLE) && start && (k_len != '0);
    assign zero_req  = (state_q == S_IDLE) && start && (k_len == '0);
    assign last_feed = (cnt_q == (CNT_W'(k_len_q) - CNT_W'(1)));

`ifdef SEQ_ABORT_EN
    assign abort_hit = abort && ((state_q == S_CLEAR) || (state_q == S_FEED) ||
                                 (state_q == S_FLUSH) || (state_q == S_WRITE));
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    // State and phase counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Job fields are captured on accept; err/aborted are one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_len_q    <= '0;
            inp_base_q <= '0;
            wt_base_q  <= '0;
            op_addr_q  <= '0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            if (accept) begin
                k_len_q    <= k_len;
                inp_base_q <= inp_base;
                wt_base_q  <= wt_base;
                op_addr_q  <= op_addr;
            end
            err_q     <= zero_req;
            aborted_q <= abort_hit;
        end
    end

    // Next-state and phase counter sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (last_feed) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (cnt_q == CNT_W'(2 * ARR_SIZE - 1)) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (cnt_q == CNT_W'(ARR_SIZE - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort_hit) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Output decode from the registered state and counter.
    always_comb begin
        ready       = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        err         = err_q;
        aborted     = aborted_q;
        inp_rd_en   = 1'b0;
        inp_rd_addr = '0;
        wt_rd_en    = 1'b0;
        wt_rd_addr  = '0;
        acc_reset   = 1'b0;
        acc_capture = 1'b0;
        acc_op_addr = '0;
        case (state_q)
            S_CLEAR: acc_reset = 1'b1;
            S_FEED: begin
                inp_rd_en   = 1'b1;
                wt_rd_en    = 1'b1;
                inp_rd_addr = inp_base_q + ADDR_W'(cnt_q);
                wt_rd_addr  = wt_base_q + ADDR_W'(cnt_q);
            end
            S_WRITE: begin
                acc_capture = 1'b1;
                acc_op_addr = op_addr_q + OP_W'(cnt_q);
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    skew_shift #(
        .ARR_SIZE (ARR_SIZE)
    ) u_skew (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (abort_hit),
        .valid_i (inp_rd_en),
        .valid_o (feed_valid)
    );

endmodule

// File: tb/tb_compute_sequencer.sv
// Self-checking bench for compute_sequencer against a job-timeline model.
module tb_compute_sequencer;

    localparam int A  = 4;
    localparam int KW = 8;

`ifdef SEQ_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic [14:0]   inp_base;
    logic [14:0]   wt_base;
    logic [3:0]    op_addr;
    logic          abort;
    logic          ready, busy, done, aborted, err;
    logic          inp_rd_en, wt_rd_en;
    logic [14:0]   inp_rd_addr, wt_rd_addr;
    logic [A-1:0]  feed_valid;
    logic          acc_reset, acc_capture;
    logic [3:0]    acc_op_addr;

    compute_sequencer #(.ARR_SIZE(A), .K_W(KW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .inp_base    (inp_base),
        .wt_base     (wt_base),
        .op_addr     (op_addr),
        .abort       (abort),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .err         (err),
        .inp_rd_en   (inp_rd_en),
        .inp_rd_addr (inp_rd_addr),
        .wt_rd_en    (wt_rd_en),
        .wt_rd_addr  (wt_rd_addr),
        .feed_valid  (feed_valid),
        .acc_reset   (acc_reset),
        .acc_capture (acc_capture),
        .acc_op_addr (acc_op_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a job is a timeline of cycles 1..k+3A+2 counted from its accept edge.
    bit          m_job;
    int          m_rel;
    int          m_k, m_ib, m_wb, m_op;
    bit          m_err, m_ab;
    logic [31:0] m_hist;
    bit          chk_en;
    int          checks, errors, cyc;
    int          done_cnt;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit m_reading();
        return m_job && (m_rel >= 2) && (m_rel <= m_k + 1);
    endfunction

    task automatic check_outputs();
        bit rd, cap;
        int n, row;
        rd  = m_reading();
        cap = m_job && (m_rel >= m_k + 2*A + 2) && (m_rel <= m_k + 3*A + 1);
        n   = m_rel - 2;
        row = m_rel - (m_k + 2*A + 2);
        check_val("ready",       32'(ready),       32'(!m_job));
        check_val("busy",        32'(busy),        32'(m_job));
        check_val("acc_reset",   32'(acc_reset),   32'(m_job && m_rel == 1));
        check_val("inp_rd_en",   32'(inp_rd_en),   32'(rd));
        check_val("wt_rd_en",    32'(wt_rd_en),    32'(rd));
        check_val("inp_rd_addr", 32'(inp_rd_addr), rd ? 32'((m_ib + n) % 32768) : 32'd0);
        check_val("wt_rd_addr",  32'(wt_rd_addr),  rd ? 32'((m_wb + n) % 32768) : 32'd0);
        check_val("feed_valid",  32'(feed_valid),  32'(m_hist[A-1:0]));
        check_val("acc_capture", 32'(acc_capture), 32'(cap));
        check_val("acc_op_addr", 32'(acc_op_addr), cap ? 32'((m_op + row) % 16) : 32'd0);
        check_val("done",        32'(done),        32'(m_job && m_rel == m_k + 3*A + 2));
        check_val("err",         32'(err),         32'(m_err));
        check_val("aborted",     32'(aborted),     32'(m_ab));
    endtask

    task automatic model_update(input bit r, input bit s, input int k, input int ib,
                                input int wb, input int op, input bit ab);
        bit rd_now;
        rd_now = m_reading();
        if (r) begin
            m_job  = 1'b0;
            m_rel  = 0;
            m_err  = 1'b0;
            m_ab   = 1'b0;
            m_hist = '0;
        end else begin
            m_hist = (m_hist << 1) | 32'(rd_now);
            m_err  = !m_job && s && (k == 0);
            if (ABORT_EN && ab && m_job && (m_rel <= m_k + 3*A + 1)) begin
                m_job  = 1'b0;
                m_ab   = 1'b1;
                m_hist = '0;
            end else begin
                m_ab = 1'b0;
                if (m_job) begin
                    if (m_rel == m_k + 3*A + 2) begin
                        m_job = 1'b0;
                        done_cnt++;
                    end else begin
                        m_rel++;
                    end
                end else if (s && k != 0) begin
                    m_job = 1'b1;
                    m_rel = 1;
                    m_k   = k;
                    m_ib  = ib;
                    m_wb  = wb;
                    m_op  = op;
                end
            end
        end
    endtask

    // One clock: check this cycle's outputs, then drive the inputs for the next edge.
    task automatic step(input bit r, input bit s, input int k, input int ib,
                        input int wb, input int op, input bit ab);
        @(negedge clk);
        cyc++;
        if (chk_en) check_outputs();
        rst      = r;
        start    = s;
        k_len    = KW'(k);
        inp_base = 15'(ib);
        wt_base  = 15'(wb);
        op_addr  = 4'(op);
        abort    = ab;
        model_update(r, s, k, ib, wb, op, ab);
        if (r) chk_en = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic run_to_idle();
        for (int i = 0; i < 400 && m_job; i++) idle();
        idle();
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        k_len = '0; inp_base = '0; wt_base = '0; op_addr = '0;
        m_job = 1'b0; m_rel = 0; m_hist = '0; m_err = 1'b0; m_ab = 1'b0;
        m_k = 0; m_ib = 0; m_wb = 0; m_op = 0;
        chk_en = 1'b0; checks = 0; errors = 0; cyc = 0; done_cnt = 0;

        repeat (3) step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        idle();

        // Reference job: reads 0x10..0x12, writes rows 2..5, done in cycle 17.
        step(1'b0, 1'b1, 3, 'h10, 'h20, 2, 1'b0);
        run_to_idle();

        // Zero-length request flags err and never leaves IDLE.
        step(1'b0, 1'b1, 0, 5, 6, 7, 1'b0);
        repeat (3) idle();

        // Address wrap on both buffers and the output row address.
        step(1'b0, 1'b1, 4, 'h7FFE, 'h7FFF, 14, 1'b0);
        run_to_idle();

        // start held high: one job at a time, the next taken right after done.
        d0 = done_cnt;
        for (int i = 0; i < 2 * (2 + 3*A + 3) + 2; i++)
            step(1'b0, 1'b1, 2, 'h100, 'h200, 7, 1'b0);
        run_to_idle();
        check_val("held_start_jobs", 32'(done_cnt - d0), 32'd3);

        // Reset mid-flush discards the job.
        d0 = done_cnt;
        step(1'b0, 1'b1, 2, 'h33, 'h44, 1, 1'b0);
        for (int i = 0; i < 50 && !(m_job && m_rel >= 2 + 2 + 1); i++) idle();
        step(1'b1, 1'b1, 2, 'h33, 'h44, 1, 1'b1);
        repeat (3) idle();
        check_val("rst_flush_no_done", 32'(done_cnt - d0), 32'd0);

        // Abort on the third feed cycle (ignored when the feature is off).
        d0 = done_cnt;
        step(1'b0, 1'b1, 6, 'h40, 'h50, 9, 1'b0);
        for (int i = 0; i < 20 && m_rel < 4; i++) idle();
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        run_to_idle();
        check_val("abort_done_count", 32'(done_cnt - d0), ABORT_EN ? 32'd0 : 32'd1);

        // Randomized traffic including rare resets and aborts.
        for (int i = 0; i < 2000; i++) begin
            bit r, s, ab;
            int k, ib, wb, op;
            r  = ($urandom_range(0, 149) == 0);
            s  = ($urandom_range(0, 2) == 0);
            ab = ($urandom_range(0, 39) == 0);
            k  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
            ib = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 32767))
                                             : 32768 - int'($urandom_range(1, 8));
            wb = int'($urandom_range(0, 32767));
            op = int'($urandom_range(0, 15));
            step(r, s, k, ib, wb, op, ab);
        end
        run_to_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/compute_sequencer.md
COMPUTE_SEQUENCER -- requirements
Module: compute_sequencer

Interface
REQ-001 Parameter ARR_SIZE, default 4: systolic array dimension (lanes, result rows).
REQ-002 Parameter K_W, default 8: width of the accumulation-depth field.
REQ-003 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-004 Ports: rst  in  1  reset, synchronous, active-high.
REQ-005 Ports: start  in  1; k_len  in  K_W; inp_base  in  15; wt_base  in  15; op_addr  in  4 -- job request and its fields.
REQ-006 Ports: abort  in  1  job cancel; honoured only with SEQ_ABORT_EN.
REQ-007 Ports: ready  out  1; busy  out  1; done  out  1 (pulse); aborted  out  1 (pulse); err  out  1 (pulse).
REQ-008 Ports: inp_rd_en  out  1; inp_rd_addr  out  15; wt_rd_en  out  1; wt_rd_addr  out  15 -- input/weight buffer reads.
REQ-009 Ports: feed_valid  out  ARR_SIZE  per-lane skewed valid into the array.
REQ-010 Ports: acc_reset  out  1; acc_capture  out  1; acc_op_addr  out  4 -- accumulator clear, write-out strobe, output-buffer address.

Function
REQ-011 States IDLE, CLEAR, FEED, FLUSH, WRITE, DONE; ready=1 only in IDLE; busy=1 in every other state.
REQ-012 IDLE: start=1 and k_len!=0 latches k_len, inp_base, wt_base, op_addr and moves to CLEAR; start=1 with k_len=0 pulses err for one cycle and stays IDLE.
REQ-013 start outside IDLE is ignored: no latch, no err.
REQ-014 CLEAR: one cycle, acc_reset=1, then FEED.
REQ-015 FEED: exactly k_len cycles; each cycle inp_rd_en=wt_rd_en=1, addresses base+n (n=0..k_len-1), modulo 2^15 wrap; then FLUSH.
REQ-016 Read latency is 1 cycle; feed_valid[i] is inp_rd_en delayed by 1+i cycles.
REQ-017 FLUSH: exactly 2*ARR_SIZE cycles, no reads; then WRITE.
REQ-018 WRITE: ARR_SIZE cycles, acc_capture=1, acc_op_addr=op_addr+row (row=0..ARR_SIZE-1), modulo 16 wrap; then DONE.
REQ-019 DONE: done=1 for one cycle, then IDLE; new start is accepted no earlier than the following cycle.
REQ-020 With accept at edge E0, the cycle after E0 is cycle 1: CLEAR in cycle 1, FEED in cycles 2..k_len+1, done in cycle k_len+3*ARR_SIZE+2.
REQ-021 Outside their states, rd_en, acc_reset, acc_capture, done, err and aborted are 0; addresses hold 0.

Reset
REQ-022 rst=1 at an edge forces IDLE and zeroes all outputs, latched fields and the skew line, except ready=1, from the following cycle; this applies mid-job, and the job is discarded with no done.
REQ-023 rst has priority over start and abort in the same cycle.

Configuration
REQ-024 SEQ_ABORT_EN defined: abort=1 in CLEAR, FEED, FLUSH or WRITE returns to IDLE next cycle, pulses aborted, clears the skew line, issues no capture or done.
REQ-025 abort=1 in DONE lets DONE complete normally.
REQ-026 SEQ_ABORT_EN undefined: abort is ignored and aborted is held at 0.

Structure
REQ-027 Package accel_pkg holds the state enum, address widths (15, 4) and the read-latency constant.
REQ-028 One sub-module, skew_shift: an ARR_SIZE-deep valid delay line with synchronous clear.

Verification
REQ-029 ARR_SIZE=4, start with k_len=3, inp_base=0x10, wt_base=0x20, op_addr=2 -> inp_rd_addr 0x10..0x12 in cycles 2..4; acc_op_addr 2,3,4,5 in cycles 13..16; done in cycle 17.
REQ-030 start with k_len=0 -> err pulses one cycle; no reads; ready stays 1.
REQ-031 inp_base=0x7FFE, k_len=4 -> inp_rd_addr 0x7FFE, 0x7FFF, 0x0000, 0x0001; op_addr=14 -> acc_op_addr 14, 15, 0, 1.
REQ-032 start held high through a job -> exactly one job runs; second job accepted in the cycle after done.
REQ-033 rst=1 during FLUSH -> next cycle IDLE, all outputs 0, ready=1, no done.
REQ-034 SEQ_ABORT_EN, abort in FEED cycle 3 -> aborted pulse next cycle, feed_valid all 0, no acc_capture; without the macro, same stimulus -> normal done.
